// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared state encoding and defaults for count_seq_ctrl
// Contents: DEFAULT_WIDTH, state encoding localparams, state_t, state decode helpers.
package count_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
   localparam logic [2:0] ST_ARMED_ENC = 3'd1;
   localparam logic [2:0] ST_RUN_ENC   = 3'd2;
   localparam logic [2:0] ST_HOLD_ENC  = 3'd3;
   localparam logic [2:0] ST_DONE_ENC  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_ARMED = ST_ARMED_ENC,
      ST_RUN   = ST_RUN_ENC,
      ST_HOLD  = ST_HOLD_ENC,
      ST_DONE  = ST_DONE_ENC
   } state_t;

   // The counter is owned by a run while counting or paused.
   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

   // A new configuration may only replace the old one when no run is active.
   function automatic logic accepts_cfg(input state_t s);
      return (s == ST_IDLE) || (s == ST_ARMED) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/up_counter_core.sv
// rtl/up_counter_core.sv - free-running up-counter datapath with clear and enable
// Ports: clk, rst (sync, active-high), clr (wins over en), en (increment), c (count).
module up_counter_core
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] c
);

   always_ff @(posedge clk) begin
      if (rst) begin
         c <= '0;
      end else if (clr) begin
         c <= '0;
      end else if (en) begin
         c <= c + WIDTH'(1);
      end
   end

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - sequencing controller that owns the up-counter clear and enable
// Ports: clk, rst (sync, active-high); cfg_valid/cfg_ready/cfg_limit/cfg_reload config
// handshake; start, pause (level), abort controls; c count, tc terminal pulse,
// done one-shot complete level, busy (RUN or HOLD).
module count_seq_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_reload,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] c,
   output logic             tc,
   output logic             done,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] limit;
   logic             reload;

   logic cfg_hs;
   logic cfg_load;
   logic at_limit;
   logic cnt_clr;
   logic cnt_en;
   logic tc_nxt;

   assign cfg_hs   = cfg_valid && cfg_ready;
   assign at_limit = (c == limit);

   // Next-state and counter-control decode, in priority order: abort, config
   // handshake, pause, start, count. Abort has nothing to undo in IDLE, so a
   // handshake offered there is still taken.
   always_comb begin
      state_nxt = state;
      cfg_load  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      tc_nxt    = 1'b0;

      if (abort && (state != ST_IDLE)) begin
         state_nxt = ST_IDLE;
         cnt_clr   = 1'b1;
      end else if (cfg_hs) begin
         state_nxt = ST_ARMED;
         cfg_load  = 1'b1;
         cnt_clr   = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_ARMED, ST_DONE: begin
               // pause is not looked at here; it takes effect once in RUN.
               if (start) begin
                  state_nxt = ST_RUN;
                  cnt_clr   = 1'b1;
               end
            end
            ST_RUN, ST_HOLD: begin
               // Leaving HOLD is itself a counting edge, so every HOLD cycle
               // costs exactly one cycle of latency.
               if (pause) begin
                  state_nxt = ST_HOLD;
               end else begin
                  state_nxt = ST_RUN;
                  if (!at_limit) begin
                     cnt_en = 1'b1;
                  end else begin
                     tc_nxt = 1'b1;
                     if (reload) begin
                        cnt_clr = 1'b1;
                     end else begin
                        state_nxt = ST_DONE;
                     end
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_clr   = 1'b1;
            end
         endcase
      end
   end

   // Status outputs are registered from the next state so they line up with
   // the state register without any path from the inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         limit     <= '0;
         reload    <= 1'b0;
         tc        <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         state     <= state_nxt;
         tc        <= tc_nxt;
         done      <= (state_nxt == ST_DONE);
         busy      <= is_busy(state_nxt);
         cfg_ready <= accepts_cfg(state_nxt);
         if (cfg_load) begin
            limit  <= cfg_limit;
            reload <= cfg_reload;
         end
      end
   end

   up_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .c   (c)
   );

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - self-checking bench for count_seq_ctrl
module tb_count_seq_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [W-1:0] cfg_limit = '0;
   logic         cfg_reload = 1'b0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] c;
   logic         tc;
   logic         done;
   logic         busy;

   int n_assert = 0;
   int n_fail   = 0;
   int tc_seen  = 0;

   // Reference model: progress is the number of counting edges since the
   // last start; the count is derived from it arithmetically.
   localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_HELD = 3, M_DONE = 4;
   int m_mode  = M_IDLE;
   int m_lim   = 0;
   int m_rel   = 0;
   int m_ticks = 0;
   int m_tc    = 0;

   always #5 clk = ~clk;

   count_seq_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_limit  (cfg_limit),
      .cfg_reload (cfg_reload),
      .start      (start),
      .pause      (pause),
      .abort      (abort),
      .c          (c),
      .tc         (tc),
      .done       (done),
      .busy       (busy)
   );

   function automatic int exp_c();
      if (m_rel != 0) return m_ticks % (m_lim + 1);
      return (m_ticks > m_lim) ? m_lim : m_ticks;
   endfunction

   function automatic int exp_ready();
      return (m_mode == M_IDLE || m_mode == M_ARMED || m_mode == M_DONE) ? 1 : 0;
   endfunction

   task automatic model_edge();
      int hs;
      hs   = (cfg_valid && exp_ready() == 1) ? 1 : 0;
      m_tc = 0;
      if (rst) begin
         m_mode = M_IDLE; m_lim = 0; m_rel = 0; m_ticks = 0;
      end else if (abort && m_mode != M_IDLE) begin
         m_mode = M_IDLE; m_ticks = 0;
      end else if (hs == 1) begin
         m_mode = M_ARMED; m_lim = int'(cfg_limit); m_rel = int'(cfg_reload); m_ticks = 0;
      end else if ((m_mode == M_ARMED || m_mode == M_DONE) && start) begin
         m_mode = M_RUN; m_ticks = 0;
      end else if (m_mode == M_RUN || m_mode == M_HELD) begin
         if (pause) begin
            m_mode = M_HELD;
         end else begin
            m_mode  = M_RUN;
            m_ticks = m_ticks + 1;
            if (m_ticks % (m_lim + 1) == 0) begin
               m_tc = 1;
               if (m_rel == 0) m_mode = M_DONE;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_model();
      chk("c", int'(c), exp_c());
      chk("tc", int'(tc), m_tc);
      chk("done", int'(done), (m_mode == M_DONE) ? 1 : 0);
      chk("busy", int'(busy), (m_mode == M_RUN || m_mode == M_HELD) ? 1 : 0);
      chk("cfg_ready", int'(cfg_ready), exp_ready());
   endtask

   task automatic step(input logic r, input logic v, input int lim, input logic rl,
                       input logic st, input logic pa, input logic ab);
      @(negedge clk);
      rst = r; cfg_valid = v; cfg_limit = W'(lim); cfg_reload = rl;
      start = st; pause = pa; abort = ab;
      @(posedge clk);
      model_edge();
      #1;
      if (tc === 1'b1) tc_seen++;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cfg(input int lim, input logic rl);
      step(0, 1, lim, rl, 0, 0, 0);
   endtask

   task automatic go();
      step(0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic do_abort();
      step(0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      // Reset
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("reset_c", int'(c), 0);
      chk("reset_ready", int'(cfg_ready), 1);

      // One-shot L=5: c 0..5, single tc and done from N+6
      cfg(5, 0);
      go();
      tc_seen = 0;
      idle(5);
      chk("os5_c_at_N5", int'(c), 5);
      chk("os5_no_tc_yet", tc_seen, 0);
      idle(1);
      chk("os5_done_N6", int'(done), 1);
      chk("os5_tc_N6", int'(tc), 1);
      idle(3);
      chk("os5_tc_once", tc_seen, 1);
      chk("os5_hold_c", int'(c), 5);

      // Reload L=3: tc every 4th cycle, done stays 0
      cfg(3, 1);
      go();
      tc_seen = 0;
      idle(12);
      chk("rl3_tc_count", tc_seen, 3);
      chk("rl3_done_low", int'(done), 0);

      // Pause for 2 cycles at c=3; wrap 1 cycle after pause drops
      idle(3);
      chk("rl3_c3", int'(c), 3);
      tc_seen = 0;
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("hold_c3", int'(c), 3);
      chk("hold_no_tc", tc_seen, 0);
      idle(1);
      chk("resume_wrap_c", int'(c), 0);
      chk("resume_tc", int'(tc), 1);

      // One-shot L=7, abort at c=4
      do_abort();
      cfg(7, 0);
      go();
      idle(4);
      chk("os7_c4", int'(c), 4);
      do_abort();
      chk("abort_c", int'(c), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_tc", int'(tc), 0);
      cfg(2, 0);
      chk("abort_then_cfg_ready", int'(cfg_ready), 1);

      // L=0 one-shot, then L=0 reload
      cfg(0, 0);
      go();
      tc_seen = 0;
      idle(1);
      chk("l0_os_done", int'(done), 1);
      idle(2);
      chk("l0_os_tc_once", tc_seen, 1);
      cfg(0, 1);
      go();
      tc_seen = 0;
      idle(5);
      chk("l0_rl_tc_cont", tc_seen, 5);
      chk("l0_rl_c", int'(c), 0);

      // Start with pause in ARMED, start in RUN ignored, pause/abort at c==L
      do_abort();
      cfg(2, 1);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      idle(1);
      chk("c_at_L", int'(c), 2);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("abort_at_L_no_tc", int'(tc), 0);

      // rst in RUN at c=2 together with start and cfg_valid
      cfg(9, 1);
      go();
      idle(2);
      chk("pre_rst_c2", int'(c), 2);
      step(1, 1, 5, 1, 1, 0, 0);
      chk("rst_run_c", int'(c), 0);
      chk("rst_run_tc", int'(tc), 0);
      chk("rst_run_done", int'(done), 0);
      chk("rst_run_busy", int'(busy), 0);
      chk("rst_run_ready", int'(cfg_ready), 1);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("rst_cleared_cfg_idle", int'(busy), 0);

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 39) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
